// File: rtl/gcn_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : gcn_pkg
//  Description : Shared types and default geometry for the GCN accelerator
//                product-row memory controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package gcn_pkg;

   // Default product-memory geometry
   localparam int unsigned c_FEATURE_ROWS   = 6;
   localparam int unsigned c_WEIGHT_COLS    = 3;
   localparam int unsigned c_DOT_PROD_WIDTH = 16;

   // Layer sequencing states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

endpackage : gcn_pkg
`default_nettype wire

// File: rtl/fmw_mem_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : fmw_mem_ctrl_if
//  Description : Bus bundle between the FMxWM memory controller, the
//                combination engine (writer), the aggregation engine
//                (reader) and the product row memory.
//  Revision    : 1.0 - initial release
// ============================================================================
interface fmw_mem_ctrl_if
   import gcn_pkg::*;
#(
   parameter int unsigned FEATURE_ROWS   = c_FEATURE_ROWS,
   parameter int unsigned WEIGHT_COLS    = c_WEIGHT_COLS,
   parameter int unsigned DOT_PROD_WIDTH = c_DOT_PROD_WIDTH,
   parameter int unsigned FEATURE_WIDTH  = $clog2(FEATURE_ROWS)
) ();

   // Layer control and status
   logic                                         start;
   logic                                         busy;
   logic                                         done;
   logic                                         err;

   // Write side (combination engine -> memory)
   logic                                         wr_valid;
   logic                                         wr_ready;
   logic                                         mem_wr_en;
   logic [FEATURE_WIDTH-1:0]                     mem_write_row;

   // Read side (aggregation engine <-> memory)
   logic                                         rd_req;
   logic [FEATURE_WIDTH-1:0]                     rd_row;
   logic                                         rd_last;
   logic                                         rd_ready;
   logic [FEATURE_WIDTH-1:0]                     mem_read_row;
   logic [0:WEIGHT_COLS-1][DOT_PROD_WIDTH-1:0]   mem_rd_data;
   logic [0:WEIGHT_COLS-1][DOT_PROD_WIDTH-1:0]   rd_data;
   logic                                         rd_valid;

   // Environment side: engines and memory
   modport master (
      output start, wr_valid, rd_req, rd_row, rd_last, mem_rd_data,
      input  busy, done, err, wr_ready, mem_wr_en, mem_write_row,
             rd_ready, mem_read_row, rd_data, rd_valid
   );

   // Controller side
   modport slave (
      input  start, wr_valid, rd_req, rd_row, rd_last, mem_rd_data,
      output busy, done, err, wr_ready, mem_wr_en, mem_write_row,
             rd_ready, mem_read_row, rd_data, rd_valid
   );

endinterface : fmw_mem_ctrl_if
`default_nettype wire

// File: rtl/row_valid_tracker.sv
`default_nettype none
// ============================================================================
//  Module      : row_valid_tracker
//  Description : Per-row valid bitmap for the current layer. Bits set as rows
//                are written, clear together at layer start. Lookup reports
//                whether an index is in range and whether that row is valid.
//  Revision    : 1.0 - initial release
// ============================================================================
module row_valid_tracker #(
   parameter int unsigned ROWS  = 6,
   parameter int unsigned IDX_W = 3
) (
   input  wire logic             clk,
   input  wire logic             rst,          // async, active-low
   input  wire logic             clr_i,
   input  wire logic             set_i,
   input  wire logic [IDX_W-1:0] set_idx_i,
   input  wire logic [IDX_W-1:0] look_idx_i,
   output logic                  in_range_o,
   output logic                  hit_o
);

   localparam logic [IDX_W:0] c_LIMIT = (IDX_W+1)'(ROWS);

   logic [ROWS-1:0] row_valid_q;
   logic [ROWS-1:0] row_valid_d;

   // Next bitmap: start clears everything, otherwise an accepted write sets its row
   always_comb begin
      row_valid_d = row_valid_q;
      if (clr_i) begin
         row_valid_d = '0;
      end else if (set_i) begin
         row_valid_d[set_idx_i] = 1'b1;
      end
   end

   // Bitmap register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         row_valid_q <= '0;
      end else begin
         row_valid_q <= row_valid_d;
      end
   end

   // Lookup uses the registered bitmap, so a row being written this cycle
   // is not yet visible to a reader
   always_comb begin
      in_range_o = ({1'b0, look_idx_i} < c_LIMIT);
      hit_o      = in_range_o && row_valid_q[look_idx_i];
   end

endmodule : row_valid_tracker
`default_nettype wire

// File: rtl/fmw_mem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : fmw_mem_ctrl
//  Description : Sequencing controller for the FMxWM product row memory.
//                Writes arrive in row order from the combination engine;
//                reads arrive in any order from the aggregation engine and
//                stall until the requested row has been written this layer.
//                Signals layer completion once all rows are written and the
//                final read has been accepted.
//  Revision    : 1.0 - initial release
// ============================================================================
module fmw_mem_ctrl
   import gcn_pkg::*;
#(
   parameter int unsigned FEATURE_ROWS   = c_FEATURE_ROWS,
   parameter int unsigned WEIGHT_COLS    = c_WEIGHT_COLS,
   parameter int unsigned DOT_PROD_WIDTH = c_DOT_PROD_WIDTH,
   parameter int unsigned FEATURE_WIDTH  = $clog2(FEATURE_ROWS)
) (
   input  wire logic      clk,
   input  wire logic      rst,          // async, active-low
   fmw_mem_ctrl_if.slave  bus
);

   // Count must reach FEATURE_ROWS itself to mark "all rows written"
   localparam int unsigned         c_CNT_W = $clog2(FEATURE_ROWS + 1);
   localparam logic [c_CNT_W-1:0]  c_FULL  = c_CNT_W'(FEATURE_ROWS);

   state_e                                     state_q, state_d;
   logic [c_CNT_W-1:0]                         wr_cnt_q, wr_cnt_d;
   logic                                       last_q, last_d;
   logic                                       err_q, err_d;
   logic [0:WEIGHT_COLS-1][DOT_PROD_WIDTH-1:0] rd_data_q;
   logic                                       rd_valid_q;

   logic busy;
   logic start_act;
   logic wr_ready;
   logic wr_acc;
   logic rd_in_range;
   logic rd_hit;
   logic rd_ready;
   logic rd_acc;

   // Handshake decode
   always_comb begin
      busy      = (state_q == RUN);
      start_act = bus.start && !busy;
      wr_ready  = busy && (wr_cnt_q < c_FULL);
      wr_acc    = bus.wr_valid && wr_ready;
      rd_ready  = busy && rd_hit;
      rd_acc    = bus.rd_req && rd_ready;
   end

   row_valid_tracker #(
      .ROWS  (FEATURE_ROWS),
      .IDX_W (FEATURE_WIDTH)
   ) u_row_valid (
      .clk        (clk),
      .rst        (rst),
      .clr_i      (start_act),
      .set_i      (wr_acc),
      .set_idx_i  (wr_cnt_q[FEATURE_WIDTH-1:0]),
      .look_idx_i (bus.rd_row),
      .in_range_o (rd_in_range),
      .hit_o      (rd_hit)
   );

   // Layer FSM next state, write counter, last-read flag and error flag
   always_comb begin
      state_d  = state_q;
      wr_cnt_d = wr_cnt_q;
      last_d   = last_q;
      err_d    = err_q;
      unique case (state_q)
         IDLE, DONE: begin
            if (bus.start) begin
               state_d  = RUN;
               wr_cnt_d = '0;
               last_d   = 1'b0;
               err_d    = 1'b0;
            end
         end
         RUN: begin
            if (wr_acc) begin
               wr_cnt_d = wr_cnt_q + c_CNT_W'(1);
            end
            if (rd_acc && bus.rd_last) begin
               last_d = 1'b1;
            end
            if (bus.rd_req && !rd_in_range) begin
               err_d = 1'b1;
            end
            // Completion may come from the final write or the final read,
            // whichever lands second (or both in one cycle)
            if (last_d && (wr_cnt_d == c_FULL)) begin
               state_d = DONE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Control state registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         wr_cnt_q <= '0;
         last_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         wr_cnt_q <= wr_cnt_d;
         last_q   <= last_d;
         err_q    <= err_d;
      end
   end

   // Read response: capture memory output on accept, pulse valid next cycle
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         rd_valid_q <= rd_acc;
         if (rd_acc) begin
            rd_data_q <= bus.mem_rd_data;
         end
      end
   end

   assign bus.busy          = busy;
   assign bus.done          = (state_q == DONE);
   assign bus.err           = err_q;
   assign bus.wr_ready      = wr_ready;
   assign bus.mem_wr_en     = wr_acc;
   assign bus.mem_write_row = wr_cnt_q[FEATURE_WIDTH-1:0];
   assign bus.rd_ready      = rd_ready;
   assign bus.mem_read_row  = bus.rd_row;
   assign bus.rd_data       = rd_data_q;
   assign bus.rd_valid      = rd_valid_q;

endmodule : fmw_mem_ctrl
`default_nettype wire

// File: tb/tb_fmw_mem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fmw_mem_ctrl
//  Description : Self-checking bench for fmw_mem_ctrl with a behavioural
//                layer model, a product-memory model and a read scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fmw_mem_ctrl;

   localparam int ROWS = 6;
   localparam int COLS = 3;
   localparam int DW   = 16;
   localparam int FW   = 3;

   typedef logic [0:COLS-1][DW-1:0] row_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   fmw_mem_ctrl_if bus_if ();

   fmw_mem_ctrl dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   // Product memory: synchronous write, combinational read
   row_t mem_arr [0:7];
   row_t wdata;
   always @(posedge clk) begin
      if (bus_if.mem_wr_en) mem_arr[bus_if.mem_write_row] <= wdata;
   end
   assign bus_if.mem_rd_data = mem_arr[bus_if.mem_read_row];

   int total = 0;
   int bad   = 0;

   // Layer model: 0 idle, 1 running, 2 finished
   int   m_state;
   int   m_cnt;
   bit   m_last;
   bit   m_err;
   row_t m_rows [0:ROWS-1];
   row_t exp_q [$];

   task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard monitor: every accepted read must yield exactly one rd_valid
   row_t mon_e;
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (bus_if.rd_valid || exp_q.size() > 0) begin
            if (exp_q.size() == 0) begin
               chk("rd_valid_spurious", 1, 0);
            end else begin
               mon_e = exp_q.pop_front();
               chk("rd_valid", bus_if.rd_valid, 1);
               chk("rd_data", bus_if.rd_data, mon_e);
            end
         end
      end
   end

   // One cycle: drive inputs, check outputs against the model, advance model
   task automatic step(input bit st, input bit wv, input bit rq,
                       input logic [FW-1:0] row, input bit lst, output bit rd_ok);
      bit busy_e, wr_rdy_e, rd_rdy_e, wacc, racc;
      @(negedge clk);
      bus_if.start    = st;
      bus_if.wr_valid = wv;
      bus_if.rd_req   = rq;
      bus_if.rd_row   = row;
      bus_if.rd_last  = lst;
      wdata           = row_t'({$urandom(), $urandom()});
      #1;
      busy_e   = (m_state == 1);
      wr_rdy_e = busy_e && (m_cnt < ROWS);
      rd_rdy_e = busy_e && (int'(row) < ROWS) && (int'(row) < m_cnt);
      chk("busy",          bus_if.busy, busy_e);
      chk("done",          bus_if.done, m_state == 2);
      chk("err",           bus_if.err, m_err);
      chk("wr_ready",      bus_if.wr_ready, wr_rdy_e);
      chk("mem_wr_en",     bus_if.mem_wr_en, wv && wr_rdy_e);
      chk("mem_write_row", bus_if.mem_write_row, m_cnt);
      chk("rd_ready",      bus_if.rd_ready, rd_rdy_e);
      chk("mem_read_row",  bus_if.mem_read_row, row);
      rd_ok = rd_rdy_e;
      wacc  = wv && wr_rdy_e;
      racc  = rq && rd_rdy_e;
      if (racc) exp_q.push_back(m_rows[row]);
      if (wacc) begin
         m_rows[m_cnt] = wdata;
         m_cnt++;
      end
      if (busy_e && rq && int'(row) >= ROWS) m_err = 1'b1;
      if (racc && lst) m_last = 1'b1;
      if (busy_e && m_last && m_cnt == ROWS) m_state = 2;
      if (!busy_e && st) begin
         m_state = 1;
         m_cnt   = 0;
         m_err   = 1'b0;
         m_last  = 1'b0;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst             = 1'b0;
      bus_if.start    = 1'b0;
      bus_if.wr_valid = 1'b0;
      bus_if.rd_req   = 1'b0;
      bus_if.rd_last  = 1'b0;
      #1;
      chk("rst_busy",      bus_if.busy, 0);
      chk("rst_done",      bus_if.done, 0);
      chk("rst_err",       bus_if.err, 0);
      chk("rst_rd_valid",  bus_if.rd_valid, 0);
      chk("rst_wr_ready",  bus_if.wr_ready, 0);
      chk("rst_write_row", bus_if.mem_write_row, 0);
      chk("rst_rd_ready",  bus_if.rd_ready, 0);
      m_state = 0;
      m_cnt   = 0;
      m_last  = 1'b0;
      m_err   = 1'b0;
      exp_q.delete();
      @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      bit               ok;
      bit               pend;
      bit               rq;
      bit               lst;
      logic [FW-1:0]    row;

      bus_if.start    = 1'b0;
      bus_if.wr_valid = 1'b0;
      bus_if.rd_req   = 1'b0;
      bus_if.rd_row   = '0;
      bus_if.rd_last  = 1'b0;
      wdata           = '0;
      for (int i = 0; i < 8; i++) mem_arr[i] = '0;
      for (int i = 0; i < ROWS; i++) m_rows[i] = '0;
      do_reset();

      // Full layer: six writes, then reads 5, 0, 3 (last)
      step(1, 0, 0, 0, 0, ok);
      for (int i = 0; i < 7; i++) step(0, 1, 0, 0, 0, ok);
      step(0, 0, 1, 5, 0, ok);
      step(0, 0, 1, 0, 0, ok);
      step(0, 0, 1, 3, 1, ok);
      step(0, 0, 0, 0, 0, ok);
      chk("layer1_done", bus_if.done, 1);

      // Stalled reads, same-cycle hazard, out-of-range, early rd_last
      step(1, 0, 0, 0, 0, ok);
      step(0, 1, 0, 0, 0, ok);
      step(0, 1, 1, 2, 0, ok);
      step(0, 1, 1, 2, 0, ok);     // row 2 written now, read stalls
      step(0, 0, 1, 2, 0, ok);     // accepted with new data
      chk("stall_row2_accept", ok, 1);
      step(0, 1, 1, 3, 0, ok);     // write row 3 and read row 3 together
      chk("hazard_row3_stall", bus_if.rd_ready, 0);
      step(0, 0, 1, 3, 0, ok);
      step(0, 0, 1, 7, 0, ok);     // out of range
      step(0, 0, 1, 1, 0, ok);
      chk("err_sticky", bus_if.err, 1);
      step(0, 0, 1, 0, 1, ok);     // rd_last after four writes
      step(0, 1, 0, 0, 0, ok);
      chk("early_last_run", bus_if.busy, 1);
      step(0, 1, 0, 0, 0, ok);     // sixth write completes the layer
      step(0, 0, 0, 0, 0, ok);
      chk("early_last_done", bus_if.done, 1);

      // Reset in the middle of a layer, then restart from row 0
      step(1, 0, 0, 0, 0, ok);
      for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, ok);
      do_reset();
      step(1, 0, 0, 0, 0, ok);
      step(0, 1, 0, 0, 0, ok);

      // Randomized layers with requesters holding until accepted
      pend = 1'b0;
      row  = '0;
      lst  = 1'b0;
      for (int layer = 0; layer < 8; layer++) begin
         step(1, 0, 0, 0, 0, ok);
         for (int cyc = 0; cyc < 40; cyc++) begin
            if (layer == 5 && cyc == 17) begin
               do_reset();
               pend = 1'b0;
               step(1, 0, 0, 0, 0, ok);
            end
            if (!pend) begin
               rq  = ($urandom_range(0, 2) != 0);
               row = FW'($urandom_range(0, 12) == 0 ? $urandom_range(6, 7) : $urandom_range(0, 5));
               lst = ($urandom_range(0, 9) == 0);
            end
            pend = rq;
            step($urandom_range(0, 15) == 0, $urandom_range(0, 1) == 1, rq, row, lst, ok);
            if (ok || int'(row) >= ROWS) pend = 1'b0;
            if (!pend) rq = 1'b0;
         end
      end

      step(0, 0, 0, 0, 0, ok);
      step(0, 0, 0, 0, 0, ok);
      chk("scoreboard_drained", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_fmw_mem_ctrl
`default_nettype wire
